// File: rtl/uart_cfg_master.sv
// uart_cfg_master: turns a byte stream from a UART receive path into
// register-bus accesses and returns a response byte stream.
//   Command byte : bit7 write(1)/read(0), bits6:5 sync marker 2'b01, bits4:0 address.
//   Write        : command + 4 data bytes (LSB first) -> bus write -> response 0xA5.
//   Read         : command -> bus read -> response of 4 bytes (LSB first).
//   Error        : bad sync, rx error or inter-byte timeout -> response 0xEE.
// Ports
//   clk, rst_i                     clock, asynchronous active-low reset
//   rx_data_valid_i/rx_data_i      received byte strobe and value
//   rx_err_i                       receive-path error strobe
//   tx_data_o/tx_valid_o/tx_ready_i response byte handshake
//   cfg_cs_o/cfg_we_o/cfg_addr_o/cfg_data_o  register-bus request
//   cfg_data_i                     read data, valid the cycle after the read pulse
//   busy_o                         high whenever not idle
//   drop_o                         sticky: byte arrived while none was expected
module uart_cfg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        rx_data_valid_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_err_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        cfg_cs_o,
  output logic        cfg_we_o,
  output logic [4:0]  cfg_addr_o,
  output logic [31:0] cfg_data_o,
  input  logic [31:0] cfg_data_i,
  output logic        busy_o,
  output logic        drop_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_DATA  = 3'd1,
    ACCESS    = 3'd2,
    READ_WAIT = 3'd3,
    SEND      = 3'd4,
    ERR       = 3'd5
  } state_e;

  state_e           state_q,    state_d;
  logic [4:0]       addr_q,     addr_d;
  logic             we_q,       we_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q,  tmo_cnt_d;
  logic [31:0]      resp_q,     resp_d;
  logic [1:0]       tx_idx_q,   tx_idx_d;
  logic [1:0]       tx_last_q,  tx_last_d;
  logic             drop_q,     drop_d;
  logic [7:0]       tx_data_q,  tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             cs_q,       cs_d;
  logic             cfg_we_q,   cfg_we_d;
  logic [4:0]       cfg_addr_q, cfg_addr_d;
  logic [31:0]      cfg_data_q, cfg_data_d;
  logic             busy_q,     busy_d;

  // Next-state and next-output logic; outputs are decoded from the next state
  // so that every output is a flop yet lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    resp_d     = resp_q;
    tx_idx_d   = tx_idx_q;
    tx_last_d  = tx_last_q;
    drop_d     = drop_q;

    case (state_q)
      IDLE: begin
        if (rx_err_i) begin
          state_d = ERR;
        end else if (rx_data_valid_i) begin
          if (rx_data_i[6:5] == 2'b01) begin
            addr_d     = rx_data_i[4:0];
            we_d       = rx_data_i[7];
            wdata_d    = '0;
            byte_cnt_d = '0;
            tmo_cnt_d  = '0;
            state_d    = rx_data_i[7] ? GET_DATA : ACCESS;
          end else begin
            state_d = ERR;
          end
        end
      end
      GET_DATA: begin
        if (rx_err_i) begin
          state_d = ERR;
        end else if (rx_data_valid_i) begin
          wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
          tmo_cnt_d = '0;
          if (byte_cnt_q == 2'd3) begin
            state_d = ACCESS;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      ACCESS: begin
        if (we_q) begin
          resp_d    = 32'h0000_00A5;
          tx_idx_d  = 2'd0;
          tx_last_d = 2'd0;
          state_d   = SEND;
        end else begin
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        resp_d    = cfg_data_i;
        tx_idx_d  = 2'd0;
        tx_last_d = 2'd3;
        state_d   = SEND;
      end
      SEND: begin
        if (tx_valid_q && tx_ready_i) begin
          if (tx_idx_q == tx_last_q) begin
            state_d = IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 2'd1;
          end
        end
      end
      ERR: begin
        resp_d    = 32'h0000_00EE;
        tx_idx_d  = 2'd0;
        tx_last_d = 2'd0;
        state_d   = SEND;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bytes are only expected in IDLE and GET_DATA; anything else is dropped.
    if (rx_data_valid_i && (state_q inside {ACCESS, READ_WAIT, SEND, ERR})) begin
      drop_d = 1'b1;
    end

    busy_d     = (state_d != IDLE);
    tx_valid_d = (state_d == SEND);
    tx_data_d  = tx_valid_d ? resp_d[{tx_idx_d, 3'b000} +: 8] : 8'h00;
    cs_d       = (state_d == ACCESS);
    cfg_we_d   = cs_d & we_d;
    cfg_addr_d = cs_d ? addr_d : 5'd0;
    cfg_data_d = (cs_d && we_d) ? wdata_d : 32'd0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      resp_q     <= '0;
      tx_idx_q   <= '0;
      tx_last_q  <= '0;
      drop_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cs_q       <= 1'b0;
      cfg_we_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      resp_q     <= resp_d;
      tx_idx_q   <= tx_idx_d;
      tx_last_q  <= tx_last_d;
      drop_q     <= drop_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cs_q       <= cs_d;
      cfg_we_q   <= cfg_we_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign cfg_cs_o   = cs_q;
  assign cfg_we_o   = cfg_we_q;
  assign cfg_addr_o = cfg_addr_q;
  assign cfg_data_o = cfg_data_q;
  assign busy_o     = busy_q;
  assign drop_o     = drop_q;

endmodule

// File: tb/tb_uart_cfg_master.sv
// Testbench for uart_cfg_master: directed and random commands against a
// transaction-level model (expected bus operations and response bytes).
`timescale 1ns/1ps
module tb_uart_cfg_master;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_data_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_err_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic        cfg_cs_o;
  logic        cfg_we_o;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic [31:0] cfg_data_i = 32'h0;
  logic        busy_o;
  logic        drop_o;

  uart_cfg_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .rx_data_valid_i(rx_data_valid_i),
    .rx_data_i      (rx_data_i),
    .rx_err_i       (rx_err_i),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .cfg_cs_o       (cfg_cs_o),
    .cfg_we_o       (cfg_we_o),
    .cfg_addr_o     (cfg_addr_o),
    .cfg_data_o     (cfg_data_o),
    .cfg_data_i     (cfg_data_i),
    .busy_o         (busy_o),
    .drop_o         (drop_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          rdy_mode = 0;   // 0 random, 1 always ready, 2 never ready
  logic [7:0]  obs_tx[$];
  logic [7:0]  exp_tx[$];
  logic [37:0] obs_bus[$];     // {we, addr, write data (0 on reads)}
  logic [37:0] exp_bus[$];
  logic [31:0] model_mem[32];
  logic [31:0] slave_mem[32];
  bit          slave_init = 1'b0;
  bit          rd_pend = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  bit          pend = 1'b0;
  logic [7:0]  pend_data = 8'h00;
  logic        cs_prev = 1'b0;

  function automatic logic [31:0] mem_init(input int i);
    return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'h0F0F_1234;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: what one complete command should do on the bus and tx.
  task automatic model_cmd(input logic [7:0] cmd, input logic [31:0] wdata);
    logic [4:0] a;
    a = cmd[4:0];
    if (cmd[6:5] != 2'b01) begin
      exp_tx.push_back(8'hEE);
    end else if (cmd[7]) begin
      exp_bus.push_back({1'b1, a, wdata});
      model_mem[a] = wdata;
      exp_tx.push_back(8'hA5);
    end else begin
      exp_bus.push_back({1'b0, a, 32'h0});
      for (int k = 0; k < 4; k++) exp_tx.push_back(8'(model_mem[a] >> (8 * k)));
    end
  endtask

  // Register-bus slave: read data appears only in the cycle after the read pulse.
  always @(negedge clk) begin
    if (!slave_init) begin
      for (int i = 0; i < 32; i++) slave_mem[i] = mem_init(i);
      slave_init = 1'b1;
    end
    if (rd_pend) cfg_data_i = slave_mem[rd_addr];
    else         cfg_data_i = $urandom;
    rd_pend = cfg_cs_o && !cfg_we_o;
    rd_addr = cfg_addr_o;
    if (cfg_cs_o && cfg_we_o) slave_mem[cfg_addr_o] = cfg_data_o;
  end

  // Transmit sink and bus monitor.
  always @(negedge clk) begin
    if (!rst_i) begin
      pend    = 1'b0;
      cs_prev = 1'b0;
    end else begin
      if (pend) begin
        check("tx_hold_valid", 64'(tx_valid_o), 64'(1));
        check("tx_hold_data", 64'(tx_data_o), 64'(pend_data));
      end
      case (rdy_mode)
        0:       tx_ready_i = 1'($urandom_range(0, 1));
        1:       tx_ready_i = 1'b1;
        default: tx_ready_i = 1'b0;
      endcase
      if (tx_valid_o && tx_ready_i) obs_tx.push_back(tx_data_o);
      pend      = tx_valid_o && !tx_ready_i;
      pend_data = tx_data_o;
      if (cfg_cs_o) begin
        check("cs_single_cycle", 64'(cs_prev), 64'(0));
        obs_bus.push_back({cfg_we_o, cfg_addr_o, cfg_we_o ? cfg_data_o : 32'h0});
      end else begin
        check("we_without_cs", 64'(cfg_we_o), 64'(0));
      end
      cs_prev = cfg_cs_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data_valid_i = 1'b1;
    rx_data_i       = b;
    @(negedge clk);
    rx_data_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] wdata,
                          input int unsigned lo, input int unsigned hi);
    send_byte(cmd);
    if (cmd[6:5] == 2'b01 && cmd[7]) begin
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(hi, lo)) @(negedge clk);
        send_byte(8'(wdata >> (8 * k)));
      end
    end
  endtask

  // Wait for the transaction to finish, then compare against the model.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((busy_o || obs_tx.size() < exp_tx.size()) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 64'(k < 2000), 64'(1));
    check({tag, "_tx_count"}, 64'(obs_tx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < obs_tx.size()) check({tag, "_tx_byte"}, 64'(obs_tx[i]), 64'(exp_tx[i]));
    check({tag, "_bus_count"}, 64'(obs_bus.size()), 64'(exp_bus.size()));
    for (int i = 0; i < exp_bus.size(); i++)
      if (i < obs_bus.size()) check({tag, "_bus_op"}, 64'(obs_bus[i]), 64'(exp_bus[i]));
    obs_tx.delete();
    exp_tx.delete();
    obs_bus.delete();
    exp_bus.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_valid"}, 64'(tx_valid_o), 64'(0));
    check({tag, "_tx_data"},  64'(tx_data_o),  64'(0));
    check({tag, "_cs"},       64'(cfg_cs_o),   64'(0));
    check({tag, "_we"},       64'(cfg_we_o),   64'(0));
    check({tag, "_addr"},     64'(cfg_addr_o), 64'(0));
    check({tag, "_data"},     64'(cfg_data_o), 64'(0));
    check({tag, "_busy"},     64'(busy_o),     64'(0));
    check({tag, "_drop"},     64'(drop_o),     64'(0));
  endtask

  initial begin
    int          k;
    int unsigned kind;
    logic [7:0]  cmd;
    logic [31:0] wd;
    logic [4:0]  a;

    for (int i = 0; i < 32; i++) model_mem[i] = mem_init(i);

    // Reset values, asynchronous and held across clocks.
    #2 rst_i = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    check("reset_held_busy", 64'(busy_o), 64'(0));
    rst_i = 1'b1;
    @(negedge clk);

    // Write A1,34,12,00,00 then back-to-back read of the same register.
    model_cmd(8'hA1, 32'h0000_1234);
    send_cmd(8'hA1, 32'h0000_1234, 0, 0);
    wait_done("wr_a1");
    model_cmd(8'h21, 32'h0);
    send_cmd(8'h21, 32'h0, 0, 0);
    wait_done("rd_21");

    // Register 2 holds DEADBEEF; read it back with random tx_ready.
    model_cmd(8'hA2, 32'hDEAD_BEEF);
    send_cmd(8'hA2, 32'hDEAD_BEEF, 0, 2);
    wait_done("wr_a2");
    model_cmd(8'h22, 32'h0);
    send_cmd(8'h22, 32'h0, 0, 0);
    wait_done("rd_22");

    // Bad sync marker.
    model_cmd(8'h41, 32'h0);
    send_cmd(8'h41, 32'h0, 0, 0);
    wait_done("bad_41");

    // Longest inter-byte gap that must not time out.
    model_cmd(8'hA3, 32'h0C0B_0A09);
    send_cmd(8'hA3, 32'h0C0B_0A09, 15, 15);
    wait_done("gap15");

    // Inter-byte timeout.
    send_byte(8'hA1);
    send_byte(8'h34);
    repeat (14) @(negedge clk);
    check("timeout_not_early_valid", 64'(tx_valid_o), 64'(0));
    check("timeout_not_early_busy", 64'(busy_o), 64'(1));
    exp_tx.push_back(8'hEE);
    wait_done("timeout");
    check("timeout_busy_low", 64'(busy_o), 64'(0));

    // rx_err_i wins over a simultaneous valid read command.
    rx_err_i = 1'b1;
    rx_data_valid_i = 1'b1;
    rx_data_i = 8'h22;
    @(negedge clk);
    rx_err_i = 1'b0;
    rx_data_valid_i = 1'b0;
    exp_tx.push_back(8'hEE);
    wait_done("err_prio");

    // rx_err_i while collecting write data aborts promptly.
    send_byte(8'hA1);
    send_byte(8'h34);
    rx_err_i = 1'b1;
    @(negedge clk);
    rx_err_i = 1'b0;
    k = 0;
    while (!tx_valid_o && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("err_abort_fast", 64'(tx_valid_o), 64'(1));
    exp_tx.push_back(8'hEE);
    wait_done("err_getdata");
    model_cmd(8'hA1, 32'h0000_0001);
    send_cmd(8'hA1, 32'h0000_0001, 0, 0);
    wait_done("wr_after_err");

    // Random commands, gaps and back-pressure.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      wd   = $urandom;
      a    = 5'($urandom);
      if (kind < 5)      cmd = {1'b1, 2'b01, a};
      else if (kind < 9) cmd = {1'b0, 2'b01, a};
      else begin
        cmd = 8'($urandom);
        if (cmd[6:5] == 2'b01) cmd[6] = 1'b1;
      end
      rdy_mode = (n % 4 == 3) ? 1 : 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      model_cmd(cmd, wd);
      send_cmd(cmd, wd, 0, 6);
      wait_done("rand");
    end
    rdy_mode = 0;

    // Extra byte during SEND sets drop_o and leaves the response intact.
    check("drop_initially_clear", 64'(drop_o), 64'(0));
    rdy_mode = 2;
    model_cmd(8'h25, 32'h0);
    send_cmd(8'h25, 32'h0, 0, 0);
    k = 0;
    while (!tx_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drop_reached_send", 64'(tx_valid_o), 64'(1));
    send_byte(8'h5A);
    check("drop_set", 64'(drop_o), 64'(1));
    check("drop_tx_held", 64'(tx_data_o), 64'(exp_tx[0]));
    rdy_mode = 0;
    wait_done("drop_rd");
    check("drop_sticky", 64'(drop_o), 64'(1));

    // Reset in the middle of collecting write data.
    send_byte(8'hA1);
    send_byte(8'h77);
    rst_i = 1'b0;
    #1 check("rst_mid_cmd_busy", 64'(busy_o), 64'(0));
    check("rst_mid_cmd_drop", 64'(drop_o), 64'(0));
    obs_tx.delete();
    obs_bus.delete();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_mid_cmd_no_bus", 64'(obs_bus.size()), 64'(0));
    check("rst_mid_cmd_no_tx", 64'(obs_tx.size()), 64'(0));
    check("rst_mid_cmd_idle", 64'(busy_o), 64'(0));

    // Reset in the middle of SEND.
    rdy_mode = 2;
    send_cmd(8'h26, 32'h0, 0, 0);
    k = 0;
    while (!tx_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_send_reached", 64'(tx_valid_o), 64'(1));
    rst_i = 1'b0;
    #1 check_all_zero("rst_mid_send");
    obs_tx.delete();
    obs_bus.delete();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    rdy_mode = 0;
    repeat (30) @(negedge clk);
    check("rst_mid_send_no_bus", 64'(obs_bus.size()), 64'(0));
    check("rst_mid_send_no_tx", 64'(obs_tx.size()), 64'(0));
    check("rst_mid_send_valid", 64'(tx_valid_o), 64'(0));

    // Recovery after reset.
    model_cmd(8'hA4, 32'h1357_9BDF);
    send_cmd(8'hA4, 32'h1357_9BDF, 0, 3);
    wait_done("recover_wr");
    model_cmd(8'h24, 32'h0);
    send_cmd(8'h24, 32'h0, 0, 0);
    wait_done("recover_rd");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
